drop_sequencer: RTL and testbench
=================================

Name: drop_sequencer

Overview:
Sequential controller that drives the combinational drop/display datapath (COLD/DROP/HOT decoder).
- Accepts a drop request and snapshots the temperature limit.
- Waits until the measured temperature has been below the limit for a programmable number of consecutive cycles, then asserts drop_en for a fixed window.
- Confirms the drop against the datapath's drop_activated feedback, then enforces a cooldown before the next request.
- Supplies the registered t_act/t_lim values that feed the display decoder.

Parameters:
STABLE_CYCLES, 4, consecutive "cold" samples required before dropping (1..65535)
TIMEOUT_CYCLES, 1000, max ARM cycles before FAULT (must be > STABLE_CYCLES, ≤65535)
DROP_CYCLES, 8, cycles drop_en is held high (1..65535)
COOLDOWN_CYCLES, 16, cycles requests are ignored after a drop (0..65535)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
drop_req  input  1  drop request; sampled only in IDLE, level or pulse
fault_clr  input  1  clears FAULT; sampled only in FAULT
t_act  input  16  measured temperature, unsigned
t_lim  input  16  temperature limit, unsigned
drop_activated  input  1  feedback from the display/drop datapath
drop_en  output  1  registered enable to the datapath
t_act_q  output  16  registered t_act, updated every cycle, to datapath
t_lim_q  output  16  t_lim snapshot, to datapath
state_o  output  3  current state encoding
busy  output  1  high in every state except IDLE and FAULT
done  output  1  one-cycle pulse on successful drop completion
fault  output  1  high while in FAULT

Behaviour:
- Reset (rst=1 at an edge), all outputs:
  - drop_en=0, t_act_q=0, t_lim_q=0, busy=0, done=0, fault=0.
  - State IDLE; all counters 0.
  - Reset mid-operation aborts immediately; drop_en falls on that edge.
- t_act_q <= t_act on every non-reset edge, in all states.
- cold is defined as t_act_q < t_lim_q (strict, unsigned). Equality is NOT cold.
- States (state_o encoding): IDLE=0, ARM=1, DROP=2, COOLDOWN=3, FAULT=4.
- IDLE:
  - drop_req=1 → ARM.
  - t_lim_q <= t_lim on the same edge.
  - Stable counter and timeout counter cleared.
- ARM:
  - Timeout counter +1 per cycle.
  - Stable counter +1 when cold, cleared to 0 when not cold.
  - When stable count reaches STABLE_CYCLES → DROP, drop_en <= 1 on the same edge.
  - Else when timeout count reaches TIMEOUT_CYCLES → FAULT.
  - If both conditions hit on the same edge, DROP wins.
  - t_lim changes during ARM are ignored (snapshot held).
- DROP:
  - drop_en=1 for exactly DROP_CYCLES cycles.
  - drop_activated is checked every DROP cycle. If it is 0 (temperature rose during the drop) → FAULT, drop_en <= 0 on that edge.
  - When DROP_CYCLES cycles complete → COOLDOWN, drop_en <= 0, done=1 for exactly the first COOLDOWN cycle.
- COOLDOWN:
  - drop_req ignored.
  - After COOLDOWN_CYCLES cycles → IDLE.
  - COOLDOWN_CYCLES=0 → returns to IDLE after one cycle.
- FAULT:
  - drop_en=0, fault=1.
  - fault_clr=1 → IDLE.
  - drop_req ignored; a request arriving together with fault_clr is NOT accepted.
- Counters are 16 bits wide. They saturate and never wrap; parameter bounds guarantee terminal values are reachable.
- drop_req held high across COOLDOWN→IDLE starts a new ARM on the first IDLE cycle.
- No combinational path from any input to any output. All outputs are registered or decoded from the state register.

Decomposition:
- Shared package drop_pkg:
  - State encoding constants (IDLE..FAULT, 3 bits).
  - Temperature width constant TEMP_W=16.
  - Counter width CNT_W=16.
- One natural sub-module: drop_cycle_counter, a loadable saturating down-counter with a terminal-count flag. Instantiated for stable, timeout, and window (DROP/COOLDOWN shared) counting.

Test Plan:
All scenarios use STABLE=4, TIMEOUT=20, DROP=8, COOLDOWN=16.
1. Reset mid-DROP (rst high for 1 cycle) → drop_en=0, state_o=0, t_lim_q=0 on that edge; a following drop_req with t_act=80/t_lim=100 completes normally.
2. t_lim=100, t_act=80 constant, drop_req pulse → state_o=1; drop_en rises 4 cycles after t_act_q valid, stays high 8 cycles; done pulses once; state_o=3 for 16 cycles, then 0.
3. Same, but t_act=100 (equal to t_lim) for the whole ARM → never cold; FAULT after 20 ARM cycles, fault=1, drop_en never asserted. fault_clr → IDLE.
4. t_act pattern 80,80,80,120,80,80,80,80 in ARM → stable counter restarts at the 120 sample; drop_en rises only after the final 4 cold samples.
5. During DROP, force drop_activated=0 at the 3rd DROP cycle → FAULT on that edge, drop_en=0 next cycle, done never pulses.
6. drop_req pulses in COOLDOWN and in FAULT → ignored (state unchanged). drop_req held high through COOLDOWN end → ARM on the first IDLE cycle. t_lim changed to 50 during ARM → t_lim_q stays 100.

Source files
------------

// File: rtl/drop_pkg.sv
// drop_pkg: shared definitions for the drop sequencer slice.
//   state_t : FSM state encoding, also exported on state_o
//   TEMP_W  : width of the temperature values (t_act / t_lim)
//   CNT_W   : width of every cycle counter
package drop_pkg;

  localparam int TEMP_W  = 16;
  localparam int CNT_W   = 16;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_DROP     = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

endpackage

// File: rtl/drop_cycle_counter.sv
// drop_cycle_counter: loadable saturating down-counter.
//   clk, rst  : clock and synchronous active-high reset (count -> 0)
//   load      : load load_val (takes priority over en)
//   load_val  : value to load, i.e. the number of cycles to count
//   en        : decrement by one, sticking at zero
//   last      : high while the count is 1 or 0, meaning the current
//               cycle is the final one of the loaded interval
module drop_cycle_counter
  import drop_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // Down-count with saturation at zero so the counter can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Treating 0 like 1 lets a zero-length interval still take one cycle.
  assign last = (count <= CNT_W'(1));

endmodule

// File: rtl/drop_sequencer.sv
// drop_sequencer: controller for the COLD/DROP/HOT drop datapath.
//   clk, rst        : clock, synchronous active-high reset
//   drop_req        : request a drop (accepted in IDLE only)
//   fault_clr       : leave FAULT (honoured in FAULT only)
//   t_act, t_lim    : measured temperature and limit, unsigned
//   drop_activated  : datapath feedback, must stay high during DROP
//   drop_en         : registered drop enable to the datapath
//   t_act_q/t_lim_q : registered temperature / limit snapshot to datapath
//   state_o         : current state encoding
//   busy            : high in ARM, DROP and COOLDOWN
//   done            : one-cycle pulse on the first COOLDOWN cycle
//   fault           : high while in FAULT
module drop_sequencer
  import drop_pkg::*;
#(
  parameter int STABLE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int DROP_CYCLES     = 8,
  parameter int COOLDOWN_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               drop_req,
  input  logic               fault_clr,
  input  logic [TEMP_W-1:0]  t_act,
  input  logic [TEMP_W-1:0]  t_lim,
  input  logic               drop_activated,
  output logic               drop_en,
  output logic [TEMP_W-1:0]  t_act_q,
  output logic [TEMP_W-1:0]  t_lim_q,
  output logic [STATE_W-1:0] state_o,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  localparam logic [CNT_W-1:0] STABLE_L   = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_L  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] DROP_L     = CNT_W'(DROP_CYCLES);
  localparam logic [CNT_W-1:0] COOLDOWN_L = CNT_W'(COOLDOWN_CYCLES);

  state_t state;

  logic cold;
  logic stable_load, stable_en, stable_last;
  logic timeout_load, timeout_en, timeout_last;
  logic win_load, win_en, win_last;
  logic [CNT_W-1:0] win_val;
  logic stable_hit;

  // Equality with the limit is deliberately not cold.
  assign cold       = (t_act_q < t_lim_q);
  assign stable_hit = (state == ST_ARM) && cold && stable_last;

  // Counter steering. The stable counter restarts on any warm sample; the
  // window counter is shared by DROP and COOLDOWN and reloaded on entry.
  always_comb begin
    stable_load  = 1'b0;
    stable_en    = 1'b0;
    timeout_load = 1'b0;
    timeout_en   = 1'b0;
    win_load     = 1'b0;
    win_en       = 1'b0;
    win_val      = DROP_L;
    case (state)
      ST_IDLE: begin
        stable_load  = 1'b1;
        timeout_load = 1'b1;
      end
      ST_ARM: begin
        timeout_en = 1'b1;
        if (cold) stable_en   = 1'b1;
        else      stable_load = 1'b1;
        if (stable_hit) begin
          win_load = 1'b1;
          win_val  = DROP_L;
        end
      end
      ST_DROP: begin
        if (drop_activated && win_last) begin
          win_load = 1'b1;
          win_val  = COOLDOWN_L;
        end else begin
          win_en = 1'b1;
        end
      end
      ST_COOLDOWN: win_en = 1'b1;
      default: ;
    endcase
  end

  drop_cycle_counter u_stable (
    .clk      (clk),
    .rst      (rst),
    .load     (stable_load),
    .load_val (STABLE_L),
    .en       (stable_en),
    .last     (stable_last)
  );

  drop_cycle_counter u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (timeout_load),
    .load_val (TIMEOUT_L),
    .en       (timeout_en),
    .last     (timeout_last)
  );

  drop_cycle_counter u_window (
    .clk      (clk),
    .rst      (rst),
    .load     (win_load),
    .load_val (win_val),
    .en       (win_en),
    .last     (win_last)
  );

  // Main FSM with registered drop_en/done and the temperature registers.
  // A completed stable run beats the timeout because it is tested first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      drop_en <= 1'b0;
      done    <= 1'b0;
      t_act_q <= '0;
      t_lim_q <= '0;
    end else begin
      t_act_q <= t_act;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (drop_req) begin
            state   <= ST_ARM;
            t_lim_q <= t_lim;
          end
        end
        ST_ARM: begin
          if (stable_hit) begin
            state   <= ST_DROP;
            drop_en <= 1'b1;
          end else if (timeout_last) begin
            state <= ST_FAULT;
          end
        end
        ST_DROP: begin
          if (!drop_activated) begin
            state   <= ST_FAULT;
            drop_en <= 1'b0;
          end else if (win_last) begin
            state   <= ST_COOLDOWN;
            drop_en <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_COOLDOWN: begin
          if (win_last) state <= ST_IDLE;
        end
        ST_FAULT: begin
          drop_en <= 1'b0;
          if (fault_clr) state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          drop_en <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;
  assign busy    = (state == ST_ARM) || (state == ST_DROP) || (state == ST_COOLDOWN);
  assign fault   = (state == ST_FAULT);

endmodule

// File: tb/tb_drop_sequencer.sv
// tb_drop_sequencer: directed scenarios followed by a random phase, every
// cycle compared against a behavioural model that counts cycles upward.
module tb_drop_sequencer;

  localparam int S = 4;
  localparam int T = 20;
  localparam int D = 8;
  localparam int C = 16;

  logic        clk = 1'b0;
  logic        rst, drop_req, fault_clr, drop_activated;
  logic [15:0] t_act, t_lim;
  logic        drop_en, busy, done, fault;
  logic [15:0] t_act_q, t_lim_q;
  logic [2:0]  state_o;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state (state numbers as published on state_o).
  int          m_state, m_stable, m_timeout, m_window;
  logic [15:0] m_tact, m_tlim;
  logic        m_drop_en, m_done;

  int en_seen, done_seen, rise_idx;
  bit found;
  logic [15:0] pat [8];

  drop_sequencer #(
    .STABLE_CYCLES   (S),
    .TIMEOUT_CYCLES  (T),
    .DROP_CYCLES     (D),
    .COOLDOWN_CYCLES (C)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .drop_req       (drop_req),
    .fault_clr      (fault_clr),
    .t_act          (t_act),
    .t_lim          (t_lim),
    .drop_activated (drop_activated),
    .drop_en        (drop_en),
    .t_act_q        (t_act_q),
    .t_lim_q        (t_lim_q),
    .state_o        (state_o),
    .busy           (busy),
    .done           (done),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One clock edge of the behavioural model, applied with the inputs
  // present at that edge.
  task automatic modelStep();
    bit cold;
    if (rst) begin
      m_state = 0; m_stable = 0; m_timeout = 0; m_window = 0;
      m_tact = 0; m_tlim = 0; m_drop_en = 0; m_done = 0;
    end else begin
      cold   = (m_tact < m_tlim);
      m_done = 0;
      case (m_state)
        0: if (drop_req) begin
             m_state = 1; m_tlim = t_lim; m_stable = 0; m_timeout = 0;
           end
        1: begin
             m_timeout++;
             m_stable = cold ? m_stable + 1 : 0;
             if (m_stable == S) begin
               m_state = 2; m_drop_en = 1; m_window = 0;
             end else if (m_timeout == T) begin
               m_state = 4;
             end
           end
        2: begin
             m_window++;
             if (!drop_activated) begin
               m_state = 4; m_drop_en = 0;
             end else if (m_window == D) begin
               m_state = 3; m_drop_en = 0; m_done = 1; m_window = 0;
             end
           end
        3: begin
             m_window++;
             if (m_window >= ((C > 0) ? C : 1)) m_state = 0;
           end
        4: if (fault_clr) m_state = 0;
        default: m_state = 0;
      endcase
      m_tact = t_act;
    end
  endtask

  task automatic checkOutput();
    check("state_o", {13'b0, state_o}, 16'(m_state));
    check("drop_en", {15'b0, drop_en}, {15'b0, m_drop_en});
    check("t_act_q", t_act_q, m_tact);
    check("t_lim_q", t_lim_q, m_tlim);
    check("busy",    {15'b0, busy},  16'((m_state >= 1 && m_state <= 3) ? 1 : 0));
    check("done",    {15'b0, done},  {15'b0, m_done});
    check("fault",   {15'b0, fault}, 16'((m_state == 4) ? 1 : 0));
  endtask

  task automatic applyStimulus(input logic r, input logic req, input logic clr,
                               input logic act, input logic [15:0] ta,
                               input logic [15:0] tl);
    rst = r; drop_req = req; fault_clr = clr; drop_activated = act;
    t_act = ta; t_lim = tl;
  endtask

  task automatic runCycle();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
    en_seen   += int'(drop_en);
    done_seen += int'(done);
  endtask

  initial begin
    en_seen = 0; done_seen = 0; rise_idx = -1; found = 0;
    pat[0] = 80; pat[1] = 80; pat[2] = 80; pat[3] = 120;
    pat[4] = 80; pat[5] = 80; pat[6] = 80; pat[7] = 80;

    applyStimulus(1, 0, 0, 1, 0, 0);
    runCycle();
    runCycle();

    // Normal drop: 4 cold ARM cycles, 8 DROP cycles, 16 COOLDOWN cycles.
    $display("[TB] normal drop");
    applyStimulus(0, 1, 0, 1, 80, 100);
    runCycle();
    drop_req = 0; en_seen = 0; done_seen = 0; rise_idx = -1;
    for (int i = 1; i <= 34; i++) begin
      runCycle();
      if (drop_en && rise_idx < 0) rise_idx = i;
    end
    check("s2_rise_edge", 16'(rise_idx), 16'd4);
    check("s2_en_cycles", 16'(en_seen), 16'd8);
    check("s2_done_count", 16'(done_seen), 16'd1);

    // Reset in the middle of DROP, then a clean drop.
    $display("[TB] reset mid-drop");
    drop_req = 1;
    runCycle();
    drop_req = 0;
    repeat (6) runCycle();
    check("s1_in_drop", {13'b0, state_o}, 16'd2);
    rst = 1;
    runCycle();
    check("s1_rst_drop_en", {15'b0, drop_en}, 16'd0);
    check("s1_rst_state", {13'b0, state_o}, 16'd0);
    check("s1_rst_t_lim_q", t_lim_q, 16'd0);
    rst = 0; drop_req = 1;
    runCycle();
    drop_req = 0; done_seen = 0;
    repeat (34) runCycle();
    check("s1_done_count", 16'(done_seen), 16'd1);

    // Equal temperature is never cold: timeout into FAULT.
    $display("[TB] timeout");
    drop_req = 1; t_act = 100;
    runCycle();
    drop_req = 0; en_seen = 0;
    repeat (20) runCycle();
    check("s3_fault_state", {13'b0, state_o}, 16'd4);
    check("s3_fault_flag", {15'b0, fault}, 16'd1);
    check("s3_no_drop_en", 16'(en_seen), 16'd0);
    drop_req = 1;
    runCycle();
    check("s3_req_in_fault", {13'b0, state_o}, 16'd4);
    fault_clr = 1;
    runCycle();
    drop_req = 0; fault_clr = 0;
    runCycle();
    check("s3_clr_no_arm", {13'b0, state_o}, 16'd0);

    // Warm sample in the middle of ARM restarts the stable run.
    $display("[TB] stable restart");
    t_act = pat[0]; drop_req = 1;
    runCycle();
    drop_req = 0; rise_idx = -1;
    for (int i = 1; i <= 34; i++) begin
      t_act = (i < 8) ? pat[i] : 16'd80;
      runCycle();
      if (drop_en && rise_idx < 0) rise_idx = i;
    end
    check("s4_rise_edge", 16'(rise_idx), 16'd8);

    // Feedback lost on the third DROP cycle.
    $display("[TB] lost feedback");
    t_act = 80; drop_req = 1;
    runCycle();
    drop_req = 0; done_seen = 0;
    repeat (6) runCycle();
    drop_activated = 0;
    runCycle();
    check("s5_fault_state", {13'b0, state_o}, 16'd4);
    check("s5_drop_en_low", {15'b0, drop_en}, 16'd0);
    drop_activated = 1;
    repeat (3) runCycle();
    check("s5_no_done", 16'(done_seen), 16'd0);
    fault_clr = 1;
    runCycle();
    fault_clr = 0;

    // Limit snapshot, ignored requests in COOLDOWN, held request re-arms.
    $display("[TB] snapshot and cooldown");
    drop_req = 1; t_lim = 100;
    runCycle();
    drop_req = 0; t_lim = 50;
    repeat (3) runCycle();
    check("s6_t_lim_held", t_lim_q, 16'd100);
    repeat (9) runCycle();
    check("s6_in_cooldown", {13'b0, state_o}, 16'd3);
    drop_req = 1;
    runCycle();
    drop_req = 0;
    check("s6_req_in_cooldown", {13'b0, state_o}, 16'd3);
    repeat (5) runCycle();
    drop_req = 1; t_lim = 100;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      runCycle();
      if (state_o == 3'd1) found = 1;
    end
    check("s6_rearm_reached", {15'b0, found}, 16'd1);
    drop_req = 0;
    repeat (35) runCycle();

    // Random phase.
    $display("[TB] random phase");
    for (int i = 0; i < 2500; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      drop_req       = ($urandom_range(0, 7) == 0);
      fault_clr      = ($urandom_range(0, 3) == 0);
      drop_activated = ($urandom_range(0, 31) != 0);
      t_lim          = 16'($urandom_range(95, 105));
      if ($urandom_range(0, 7) == 0) t_act = t_lim;
      else                           t_act = 16'($urandom_range(60, 110));
      runCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
